// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: one requester's valid/ready write channel into the arbiter.
// Signals: valid (write pending), addr (destination register), data (write data),
// ready (request accepted this cycle). master = requester side, slave = arbiter side.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              ready;
    modport master (output valid, addr, data, input ready);
    modport slave  (input valid, addr, data, output ready);
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter merging two register-file write requesters.
// Ports: clk, rst (sync active-high), hold (blocks all grants), a (ALU writeback) and
// b (load unit) requester channels, write_addr/write_data/write_enable (registered
// register-file write port, one cycle after the transfer), last_grant_b (1 if the most
// recent grant went to B). Defining REGFILE_ARB_STATS_EN adds conflict_cnt, a saturating
// 8-bit count of cycles where both requesters are valid and hold is low.
module regfile_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hold,
    regfile_write_arbiter_if.slave a,
    regfile_write_arbiter_if.slave b,
    output logic [ADDR_W-1:0]      write_addr,
    output logic [DATA_W-1:0]      write_data,
    output logic                   write_enable,
    output logic                   last_grant_b
`ifdef REGFILE_ARB_STATS_EN
    ,
    output logic [7:0]             conflict_cnt
`endif
);
    // prio_b set means B wins when both requesters are valid
    logic prio_b;
    logic grant_a;
    logic grant_b;
    // Grants look only at valids, hold, rst and the pointer, never at the other ready
    always_comb begin
        grant_a = !rst && !hold && a.valid && !(b.valid && prio_b);
        grant_b = !rst && !hold && b.valid && !(a.valid && !prio_b);
    end
    assign a.ready = grant_a;
    assign b.ready = grant_b;
    always_ff @(posedge clk) begin
        if (rst) begin
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            last_grant_b <= 1'b0;
            prio_b       <= 1'b0;
        end else begin
            write_enable <= grant_a || grant_b;
            if (grant_a || grant_b) begin
                write_addr   <= grant_b ? b.addr : a.addr;
                write_data   <= grant_b ? b.data : a.data;
                last_grant_b <= grant_b;
                prio_b       <= !grant_b;
            end
        end
    end
`ifdef REGFILE_ARB_STATS_EN
    logic conflict;
    assign conflict = a.valid && b.valid && !hold;
    always_ff @(posedge clk) begin
        if (rst)
            conflict_cnt <= '0;
        else if (conflict && conflict_cnt != 8'hFF)
            conflict_cnt <= conflict_cnt + 8'd1;
    end
`endif
endmodule
